// File: rtl/noc_pkg.sv
// Shared NoC definitions: output directions, flit types, header field positions
// and the XY routing function used by input ports and the switch allocator.
package noc_pkg;

  localparam int unsigned FLIT_W   = 16;
  localparam int unsigned COORD_W  = 3;
  localparam int unsigned TYPE_LSB = 14;
  localparam int unsigned DX_LSB   = 11;
  localparam int unsigned DY_LSB   = 8;

  typedef enum logic [2:0] {
    DIR_N = 3'b000,
    DIR_S = 3'b001,
    DIR_W = 3'b010,
    DIR_E = 3'b011,
    DIR_L = 3'b100
  } dir_e;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_HEAD   = 2'b01,
    FT_TAIL   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef struct packed {
    flit_type_e         ftype;
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [7:0]         payload;
  } flit_head_t;

  // Dimension-ordered routing: resolve X completely before Y.
  function automatic dir_e xy_route(input logic [COORD_W-1:0] dx,
                                    input logic [COORD_W-1:0] dy,
                                    input logic [COORD_W-1:0] cx,
                                    input logic [COORD_W-1:0] cy);
    if (dx > cx)      return DIR_E;
    else if (dx < cx) return DIR_W;
    else if (dy > cy) return DIR_N;
    else if (dy < cy) return DIR_S;
    else              return DIR_L;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// Flit FIFO with the head entry exposed combinationally; pointers wrap
// naturally because DEPTH is a power of two.
module noc_fifo #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       push,
  input  logic                       pop,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;
  logic              full;
  logic              do_push;
  logic              do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];
  assign count   = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage carries no reset; only entries below count are ever observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/noc_input_port.sv
// Router input port: buffers flits, routes the head flit XY-first, requests an
// output from the allocator and streams the granted packet into the crossbar.
module noc_input_port
  import noc_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned CUR_X  = 0,
  parameter int unsigned CUR_Y  = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [DATA_W-1:0] flit_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              req_o,
  output logic [2:0]        req_dir_o,
  input  logic              grant_i,
  output logic [DATA_W-1:0] flit_o,
  output logic [2:0]        sel_demux_o,
  output logic              flit_valid_o,
  input  logic              out_ready_i,
  output logic              release_o,
  output logic              drop_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_REQ    = 2'b01,
    ST_ACTIVE = 2'b10
  } state_e;

  state_e            state_q;
  dir_e              dir_q;
  dir_e              sel_q;
  logic [DATA_W-1:0] hold_q;

  logic [DATA_W-1:0] head;
  logic              empty;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              drop;
  logic              send;
  logic              head_is_start;
  logic              head_is_end;
  flit_type_e        head_type;
  dir_e              route;

  noc_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk_i),
    .rst_n   (rst_ni),
    .wr_data (flit_i),
    .push    (push),
    .pop     (pop),
    .rd_data (head),
    .empty   (empty),
    .count   (count)
  );

  // Acceptance depends on occupancy only, never on a same-cycle pop.
  assign ready_o = (count < CNT_W'(DEPTH));
  assign push    = valid_i & ready_o;

  assign head_type     = flit_type_e'(head[TYPE_LSB +: 2]);
  assign head_is_start = (head_type == FT_HEAD) || (head_type == FT_SINGLE);
  assign head_is_end   = (head_type == FT_TAIL) || (head_type == FT_SINGLE);
  assign route         = xy_route(head[DX_LSB +: COORD_W], head[DY_LSB +: COORD_W],
                                  COORD_W'(CUR_X), COORD_W'(CUR_Y));

  // Orphan body/tail flits at the head in IDLE are discarded.
  assign drop = (state_q == ST_IDLE) && !empty && !head_is_start;
  assign send = (state_q == ST_ACTIVE) && !empty && out_ready_i;
  assign pop  = drop | send;

  assign req_o        = (state_q == ST_REQ);
  assign req_dir_o    = dir_q;
  assign sel_demux_o  = sel_q;
  assign flit_valid_o = (state_q == ST_ACTIVE) && !empty;
  assign flit_o       = flit_valid_o ? head : hold_q;
  assign release_o    = send & head_is_end;
  assign drop_o       = drop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_N;
      sel_q   <= DIR_N;
      hold_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!empty && head_is_start) begin
            dir_q   <= route;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (grant_i) begin
            sel_q   <= dir_q;
            state_q <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          // Keep the last presented flit so the leg stays stable when the FIFO runs dry.
          if (!empty) hold_q <= head;
          if (send && head_is_end) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
